// File: rtl/flag_monitor_pkg.sv
// Shared types and default parameters for the flag monitor.
// Also holds the FSM state encoding.
package flag_monitor_pkg;

  typedef enum logic [1:0] {IDLE, QUAL, ACTIVE, DRAIN} state_e;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_HOLD  = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/flag_pair_detect.sv
// Raises cond when any two neighbouring bits of vec are both set.
module flag_pair_detect #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] vec,
  output logic             cond
);

  assign cond = |(vec[WIDTH-2:0] & vec[WIDTH-1:1]);

endmodule

// File: rtl/flag_monitor.sv
// Qualifies an adjacent-pair condition over HOLD cycles and reports a flag.
// Also produces a rise pulse and a saturating event count.
module flag_monitor
  import flag_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HOLD  = DEF_HOLD,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_bits,
  input  logic             sticky,
  input  logic             clr,
  output logic             flag,
  output logic             rise,
  output logic [CNT_W-1:0] event_cnt
);

  if (WIDTH < 2 || HOLD < 1 || HOLD > 255) begin : gBadParam
    $error("flag_monitor: illegal WIDTH or HOLD parameter");
  end

  localparam logic [7:0]       HOLD_LAST = 8'(HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [1:0]       rstSync_q;
  logic             rstSyncN;
  logic [WIDTH-1:0] in_q;
  logic             cond;
  state_e           state_q;
  logic [7:0]       holdCnt_q;
  logic             flag_q;
  logic             rise_q;
  logic [CNT_W-1:0] eventCnt_q;

  // Assertion is immediate, release waits two clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rstSync_q <= 2'b00;
    else        rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign rstSyncN = rstSync_q[1];

  flag_pair_detect #(.WIDTH(WIDTH)) uPairDetect (
    .vec  (in_q),
    .cond (cond)
  );

  always_ff @(posedge clk or negedge rstSyncN) begin
    if (!rstSyncN) begin
      in_q       <= '0;
      state_q    <= IDLE;
      holdCnt_q  <= 8'd0;
      flag_q     <= 1'b0;
      rise_q     <= 1'b0;
      eventCnt_q <= '0;
    end else begin
      in_q   <= in_bits;
      rise_q <= 1'b0;
      if (clr) begin
        state_q    <= IDLE;
        holdCnt_q  <= 8'd0;
        flag_q     <= 1'b0;
        eventCnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cond) begin
              if (HOLD == 1) begin
                state_q <= ACTIVE;
                flag_q  <= 1'b1;
                rise_q  <= 1'b1;
                if (eventCnt_q != CNT_MAX) eventCnt_q <= eventCnt_q + CNT_W'(1);
              end else begin
                state_q   <= QUAL;
                holdCnt_q <= 8'd1;
              end
            end
          end
          QUAL: begin
            if (!cond) begin
              state_q   <= IDLE;
              holdCnt_q <= 8'd0;
            end else if (holdCnt_q == HOLD_LAST) begin
              state_q   <= ACTIVE;
              holdCnt_q <= 8'd0;
              flag_q    <= 1'b1;
              rise_q    <= 1'b1;
              if (eventCnt_q != CNT_MAX) eventCnt_q <= eventCnt_q + CNT_W'(1);
            end else begin
              holdCnt_q <= holdCnt_q + 8'd1;
            end
          end
          ACTIVE: begin
            // Flag stays up through DRAIN so a short dropout is invisible.
            if (!sticky && !cond) begin
              if (HOLD == 1) begin
                state_q <= IDLE;
                flag_q  <= 1'b0;
              end else begin
                state_q   <= DRAIN;
                holdCnt_q <= 8'd1;
              end
            end
          end
          DRAIN: begin
            if (cond) begin
              state_q   <= ACTIVE;
              holdCnt_q <= 8'd0;
            end else if (holdCnt_q == HOLD_LAST) begin
              state_q   <= IDLE;
              holdCnt_q <= 8'd0;
              flag_q    <= 1'b0;
            end else begin
              holdCnt_q <= holdCnt_q + 8'd1;
            end
          end
          default: begin
            state_q   <= IDLE;
            holdCnt_q <= 8'd0;
            flag_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign flag      = flag_q;
  assign rise      = rise_q;
  assign event_cnt = eventCnt_q;

endmodule

// File: doc/flag_monitor.md
FLAG_MONITOR -- requirements
Module: flag_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 3, number of flag input bits (legal >= 2).
REQ-002 SHALL have parameter HOLD, default 4, qualification/release cycle count (legal 1..255).
REQ-003 SHALL have parameter CNT_W, default 8, event counter width.
REQ-004 SHALL use one clock and an asynchronous active-low reset: port clk, input, 1, rising-edge clock.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port in_bits, input, WIDTH, raw flag inputs.
REQ-007 Port sticky, input, 1, 1 = latch flag until clr; 0 = auto-release.
REQ-008 Port clr, input, 1, synchronous clear pulse.
REQ-009 Port flag, output, 1, qualified flag.
REQ-010 Port rise, output, 1, one-cycle pulse on new flag assertion.
REQ-011 Port event_cnt, output, CNT_W, saturating count of assertions.

Function
REQ-012 SHALL register in_bits into in_q every clock edge; all decisions use in_q.
REQ-013 cond SHALL be 1 when any adjacent pair in_q[i] and in_q[i+1] are both 1, i = 0..WIDTH-2; otherwise 0.
REQ-014 The FSM SHALL have states IDLE, QUAL, ACTIVE, DRAIN and a hold counter cnt of 8 bits.
REQ-015 IDLE: cond=1 -> ACTIVE if HOLD==1, else QUAL with cnt=1; cond=0 -> stay IDLE.
REQ-016 QUAL: cond=0 -> IDLE with cnt=0; cond=1 and cnt==HOLD-1 -> ACTIVE with cnt=0; otherwise cnt+1.
REQ-017 ACTIVE with sticky=1: stay ACTIVE regardless of cond.
REQ-018 ACTIVE with sticky=0 and cond=0: -> IDLE if HOLD==1, else DRAIN with cnt=1.
REQ-019 DRAIN: cond=1 -> ACTIVE with cnt=0; cond=0 and cnt==HOLD-1 -> IDLE with cnt=0; otherwise cnt+1.
REQ-020 Timing: in_bits qualifying at HOLD consecutive edges e..e+HOLD-1 SHALL give flag=1 from edge e+HOLD.
REQ-021 flag SHALL be 1 in ACTIVE and DRAIN and 0 in IDLE and QUAL, registered with no combinational path from inputs.
REQ-022 rise SHALL be 1 for exactly the one cycle after a transition into ACTIVE from IDLE or QUAL; it SHALL NOT pulse on DRAIN -> ACTIVE.
REQ-023 event_cnt SHALL increment whenever rise is asserted and saturate at 2^CNT_W-1.
REQ-024 clr=1 SHALL force the next state to IDLE, set cnt=0 and event_cnt=0, and suppress rise; clr takes priority over every other transition.
REQ-025 A sticky change SHALL take effect at the next edge; 1->0 while ACTIVE with cond=0 enters DRAIN on that edge.

Reset
REQ-026 rst_n=0 SHALL asynchronously set state=IDLE, cnt=0, in_q=0, flag=0, rise=0, event_cnt=0.
REQ-027 Deassertion SHALL be synchronous to clk via the standard reset synchroniser; the first qualifying sample is the first edge after release.
REQ-028 Reset mid-QUAL or mid-DRAIN SHALL discard the partial count.

Structure
REQ-029 Package flag_monitor_pkg SHALL hold the state enum (IDLE, QUAL, ACTIVE, DRAIN) and the default parameter constants.
REQ-030 The adjacent-pair detect SHALL be the sub-module flag_pair_detect (parameter WIDTH, input vec, output cond).
REQ-031 An elaboration check SHALL reject WIDTH<2, HOLD<1 or HOLD>255.

Verification
REQ-032 Scenario: WIDTH=3, HOLD=4, sticky=0; in_bits=3'b011 for 4 edges -> flag=1 at edge 4, rise=1 for one cycle, event_cnt=1.
REQ-033 Scenario: in_bits=3'b011 for 3 edges then 3'b101 -> flag stays 0, rise=0, state returns to IDLE (3'b101 is non-adjacent).
REQ-034 Scenario: from ACTIVE, in_bits=0 for 2 edges then 3'b110 -> flag stays 1 throughout, no rise, event_cnt unchanged.
REQ-035 Scenario: sticky=1, ACTIVE, in_bits=0 for 10 edges -> flag stays 1; clr pulse -> flag=0 next edge, event_cnt=0.
REQ-036 Scenario: CNT_W=2, 5 qualify/release cycles -> event_cnt=3 (saturated).
REQ-037 Scenario: HOLD=1, and rst_n pulsed low mid-QUAL with HOLD=4 -> with HOLD=1, flag rises one edge after the first qualifying sample; the reset pulse clears all outputs immediately with no clock.
